// File: rtl/counter_chk_pkg.sv
// Shared types, default widths and helpers for the up/down counter checker.
package counter_chk_pkg;

    // Checker FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        HALT  = 2'd2
    } chk_state_t;

    // Default configuration.
    localparam int DEF_WIDTH       = 4;
    localparam int DEF_ERR_W       = 8;
    localparam int DEF_HALT_ON_ERR = 0;

    // Saturating increment. Callers narrow the result back to their counter
    // width, so counters up to 32 bits are supported.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        if (value >= max_value) begin
            return max_value;
        end
        return value + 32'd1;
    endfunction

endpackage

// File: rtl/counter_ref_model.sv
// Combinational next-value model of the up/down counter.
// Load has priority over direction; up and down both wrap modulo 2^WIDTH.
module counter_ref_model
    import counter_chk_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_exp_q,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_in,
    input  logic             i_is_up,
    output logic [WIDTH-1:0] o_exp_d
);

    // Next expected count: load value, or current value stepped by one.
    always_comb begin
        o_exp_d = i_exp_q;
        if (i_load) begin
            o_exp_d = i_in;
        end else if (i_is_up) begin
            o_exp_d = i_exp_q + WIDTH'(1);
        end else begin
            o_exp_d = i_exp_q - WIDTH'(1);
        end
    end

endmodule

// File: rtl/counter_checker.sv
// Observer for the up/down counter: keeps a cycle-accurate expected count,
// flags divergence with a one-cycle pulse, counts errors (saturating) and
// captures the first failure.
// Optional build macro COUNTER_CHECKER_WRAP_STATS_EN adds saturating
// up-wrap / down-wrap counters derived from the reference model.
module counter_checker
    import counter_chk_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int ERR_W       = DEF_ERR_W,
    parameter int HALT_ON_ERR = DEF_HALT_ON_ERR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             is_up,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] out,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_cnt,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_obs,
    output logic             halted,
    output logic             checking
`ifdef COUNTER_CHECKER_WRAP_STATS_EN
    ,
    output logic [ERR_W-1:0] wrap_up_cnt,
    output logic [ERR_W-1:0] wrap_dn_cnt
`endif
);

    localparam logic [31:0] ERR_MAX = 32'((64'd1 << ERR_W) - 64'd1);

    chk_state_t       r_state;
    chk_state_t       w_state_next;
    logic [WIDTH-1:0] r_exp;
    logic [WIDTH-1:0] w_exp_d;
    logic             w_miscompare;
    logic             w_checking;
    logic             w_halted;
    logic             r_mismatch;
    logic [ERR_W-1:0] r_err_cnt;
    logic [WIDTH-1:0] r_first_exp;
    logic [WIDTH-1:0] r_first_obs;

    counter_ref_model #(
        .WIDTH (WIDTH)
    ) u_ref_model (
        .i_exp_q (r_exp),
        .i_load  (load),
        .i_in    (in),
        .i_is_up (is_up),
        .o_exp_d (w_exp_d)
    );

    // Both out and r_exp reflect the previous edge, so they are compared directly.
    assign w_miscompare = (r_state == CHECK) && (out != r_exp);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and state-decoded status flags.
    always_comb begin
        w_state_next = r_state;
        w_checking   = 1'b0;
        w_halted     = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_next = CHECK;
            end
            CHECK: begin
                w_checking = 1'b1;
                if (w_miscompare && (HALT_ON_ERR != 0)) begin
                    w_state_next = HALT;
                end
            end
            HALT: begin
                w_halted = 1'b1;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Expected count: follows the model in IDLE (first live edge) and CHECK, frozen in HALT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exp <= '0;
        end else if (r_state != HALT) begin
            r_exp <= w_exp_d;
        end
    end

    // Mismatch pulse, saturating error count and first-failure capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mismatch  <= 1'b0;
            r_err_cnt   <= '0;
            r_first_exp <= '0;
            r_first_obs <= '0;
        end else begin
            r_mismatch <= w_miscompare;
            if (w_miscompare) begin
                r_err_cnt <= ERR_W'(sat_inc(32'(r_err_cnt), ERR_MAX));
                if (r_err_cnt == '0) begin
                    r_first_exp <= r_exp;
                    r_first_obs <= out;
                end
            end
        end
    end

`ifdef COUNTER_CHECKER_WRAP_STATS_EN
    logic [ERR_W-1:0] r_wrap_up;
    logic [ERR_W-1:0] r_wrap_dn;
    logic             w_wrap_up;
    logic             w_wrap_dn;

    // A load always overrides the step, so it can never be a wrap.
    assign w_wrap_up = (r_state == CHECK) && !load && is_up  && (r_exp == '1);
    assign w_wrap_dn = (r_state == CHECK) && !load && !is_up && (r_exp == '0);

    // Saturating wrap statistics taken from the reference model.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrap_up <= '0;
            r_wrap_dn <= '0;
        end else begin
            if (w_wrap_up) begin
                r_wrap_up <= ERR_W'(sat_inc(32'(r_wrap_up), ERR_MAX));
            end
            if (w_wrap_dn) begin
                r_wrap_dn <= ERR_W'(sat_inc(32'(r_wrap_dn), ERR_MAX));
            end
        end
    end

    assign wrap_up_cnt = r_wrap_up;
    assign wrap_dn_cnt = r_wrap_dn;
`endif

    assign mismatch      = r_mismatch;
    assign err_cnt       = r_err_cnt;
    assign first_err_exp = r_first_exp;
    assign first_err_obs = r_first_obs;
    assign halted        = w_halted;
    assign checking      = w_checking;

endmodule

// File: tb/tb_counter_checker.sv
// Bench for counter_checker. Three instances watch one shared counter stream:
// default config, HALT_ON_ERR=1, and ERR_W=2. A behavioural counter drives
// out; selected cycles override out to inject faults.
module tb_counter_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       is_up = 1'b0;
    logic       load = 1'b0;
    logic [3:0] in = 4'd0;
    logic [3:0] out = 4'd0;

    logic       m_mis, h_mis, s_mis;
    logic [7:0] m_err, h_err;
    logic [1:0] s_err;
    logic [3:0] m_fe, m_fo, h_fe, h_fo, s_fe, s_fo;
    logic       m_halt, h_halt, s_halt;
    logic       m_chk, h_chk, s_chk;
`ifdef COUNTER_CHECKER_WRAP_STATS_EN
    logic [7:0] m_wu, m_wd, h_wu, h_wd;
    logic [1:0] s_wu, s_wd;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    counter_checker #(.WIDTH(4), .ERR_W(8), .HALT_ON_ERR(0)) dut_m (
        .clk(clk), .rst(rst), .is_up(is_up), .load(load), .in(in), .out(out),
        .mismatch(m_mis), .err_cnt(m_err), .first_err_exp(m_fe), .first_err_obs(m_fo),
        .halted(m_halt), .checking(m_chk)
`ifdef COUNTER_CHECKER_WRAP_STATS_EN
        , .wrap_up_cnt(m_wu), .wrap_dn_cnt(m_wd)
`endif
    );

    counter_checker #(.WIDTH(4), .ERR_W(8), .HALT_ON_ERR(1)) dut_h (
        .clk(clk), .rst(rst), .is_up(is_up), .load(load), .in(in), .out(out),
        .mismatch(h_mis), .err_cnt(h_err), .first_err_exp(h_fe), .first_err_obs(h_fo),
        .halted(h_halt), .checking(h_chk)
`ifdef COUNTER_CHECKER_WRAP_STATS_EN
        , .wrap_up_cnt(h_wu), .wrap_dn_cnt(h_wd)
`endif
    );

    counter_checker #(.WIDTH(4), .ERR_W(2), .HALT_ON_ERR(0)) dut_s (
        .clk(clk), .rst(rst), .is_up(is_up), .load(load), .in(in), .out(out),
        .mismatch(s_mis), .err_cnt(s_err), .first_err_exp(s_fe), .first_err_obs(s_fo),
        .halted(s_halt), .checking(s_chk)
`ifdef COUNTER_CHECKER_WRAP_STATS_EN
        , .wrap_up_cnt(s_wu), .wrap_dn_cnt(s_wd)
`endif
    );

    // ---------------- behavioural reference (per instance) ----------------
    // Index 0: default, 1: halt-on-error, 2: 2-bit error counter.
    int cnt = 0;                      // the observed counter's true value
    bit started_m[3];                 // has seen its first non-reset edge
    bit halt_m[3];
    bit mis_m[3];
    int exp_m[3];
    int err_m[3];
    int fe_m[3];
    int fo_m[3];
    int wu_m[3];
    int wd_m[3];
    bit halt_cfg[3] = '{1'b0, 1'b1, 1'b0};
    int err_max[3]  = '{255, 255, 3};

    function automatic int step_val(int e, bit ld, bit up, int v);
        if (ld) return v;
        if (up) return (e + 1) % 16;
        return (e + 15) % 16;
    endfunction

    task automatic model_edge(bit r, bit up, bit ld, int v, int o);
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                started_m[k] = 0; halt_m[k] = 0; mis_m[k] = 0;
                exp_m[k] = 0; err_m[k] = 0; fe_m[k] = 0; fo_m[k] = 0;
                wu_m[k] = 0; wd_m[k] = 0;
            end else if (!started_m[k]) begin
                started_m[k] = 1;
                mis_m[k] = 0;
                exp_m[k] = step_val(exp_m[k], ld, up, v);
            end else if (halt_m[k]) begin
                mis_m[k] = 0;
            end else begin
                mis_m[k] = (o != exp_m[k]);
                if (mis_m[k]) begin
                    if (err_m[k] == 0) begin
                        fe_m[k] = exp_m[k];
                        fo_m[k] = o;
                    end
                    if (err_m[k] < err_max[k]) err_m[k]++;
                    if (halt_cfg[k]) halt_m[k] = 1;
                end
                if (!ld && up && exp_m[k] == 15 && wu_m[k] < err_max[k]) wu_m[k]++;
                if (!ld && !up && exp_m[k] == 0 && wd_m[k] < err_max[k]) wd_m[k]++;
                exp_m[k] = step_val(exp_m[k], ld, up, v);
            end
        end
    endtask

    task automatic chk(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic compare_model();
        chk("m_mismatch", int'(m_mis), int'(mis_m[0]));
        chk("m_err_cnt", int'(m_err), err_m[0]);
        chk("m_first_exp", int'(m_fe), fe_m[0]);
        chk("m_first_obs", int'(m_fo), fo_m[0]);
        chk("m_halted", int'(m_halt), int'(halt_m[0]));
        chk("m_checking", int'(m_chk), int'(started_m[0] && !halt_m[0]));
        chk("h_mismatch", int'(h_mis), int'(mis_m[1]));
        chk("h_err_cnt", int'(h_err), err_m[1]);
        chk("h_first_exp", int'(h_fe), fe_m[1]);
        chk("h_first_obs", int'(h_fo), fo_m[1]);
        chk("h_halted", int'(h_halt), int'(halt_m[1]));
        chk("h_checking", int'(h_chk), int'(started_m[1] && !halt_m[1]));
        chk("s_mismatch", int'(s_mis), int'(mis_m[2]));
        chk("s_err_cnt", int'(s_err), err_m[2]);
        chk("s_first_exp", int'(s_fe), fe_m[2]);
        chk("s_first_obs", int'(s_fo), fo_m[2]);
        chk("s_halted", int'(s_halt), int'(halt_m[2]));
        chk("s_checking", int'(s_chk), int'(started_m[2] && !halt_m[2]));
`ifdef COUNTER_CHECKER_WRAP_STATS_EN
        chk("m_wrap_up", int'(m_wu), wu_m[0]);
        chk("m_wrap_dn", int'(m_wd), wd_m[0]);
        chk("h_wrap_up", int'(h_wu), wu_m[1]);
        chk("h_wrap_dn", int'(h_wd), wd_m[1]);
        chk("s_wrap_up", int'(s_wu), wu_m[2]);
        chk("s_wrap_dn", int'(s_wd), wd_m[2]);
`endif
    endtask

    // One clock of stimulus: drive inputs, advance model and counter, compare.
    task automatic cycle(bit r, bit up, bit ld, int v, bit inj, int iv);
        int o;
        int cnt_next;
        o = inj ? iv : cnt;
        rst   = r;
        is_up = up;
        load  = ld;
        in    = 4'(v);
        out   = 4'(o);
        model_edge(r, up, ld, v, o);
        cnt_next = r ? 0 : step_val(cnt, ld, up, v);
        @(posedge clk);
        #1;
        cnt = cnt_next;
        compare_model();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit rst; bit up; bit ld; int v; bit inj; int iv;
        bit e_mis; int e_err; bit e_chk;
    } vec_t;

    vec_t tbl[13];

    initial begin
        // rst up ld in inj iv | mismatch err checking   (default instance)
        tbl[0]  = '{1, 0, 0, 0, 0, 0,  0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 0,  0, 0, 0};
        tbl[2]  = '{0, 1, 1, 2, 0, 0,  0, 0, 1};  // load beats up: exp=2
        tbl[3]  = '{0, 1, 0, 0, 0, 0,  0, 0, 1};
        tbl[4]  = '{0, 1, 0, 0, 0, 0,  0, 0, 1};  // exp becomes 4
        tbl[5]  = '{0, 1, 0, 0, 1, 7,  1, 1, 1};  // out=7 while exp=4
        tbl[6]  = '{0, 1, 0, 0, 0, 0,  0, 1, 1};  // pulse lasts one cycle
        tbl[7]  = '{0, 0, 0, 0, 0, 0,  0, 1, 1};
        tbl[8]  = '{0, 0, 1, 0, 0, 0,  0, 1, 1};  // load 0
        tbl[9]  = '{0, 0, 0, 0, 0, 0,  0, 1, 1};  // down wrap 0 -> 15
        tbl[10] = '{0, 1, 0, 0, 0, 0,  0, 1, 1};  // up wrap 15 -> 0
        tbl[11] = '{0, 1, 0, 0, 1, 9,  1, 2, 1};  // out=9 while exp=0
        tbl[12] = '{1, 0, 0, 0, 0, 0,  0, 0, 0};  // mid-run reset clears

        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].rst, tbl[i].up, tbl[i].ld, tbl[i].v, tbl[i].inj, tbl[i].iv);
            $display("vec %0d: rst=%0b up=%0b ld=%0b in=%0d out=%0d -> mismatch=%0b err_cnt=%0d checking=%0b",
                     i, tbl[i].rst, tbl[i].up, tbl[i].ld, tbl[i].v, int'(out), m_mis, m_err, m_chk);
            chk("tbl_mismatch", int'(m_mis), int'(tbl[i].e_mis));
            chk("tbl_err_cnt", int'(m_err), tbl[i].e_err);
            chk("tbl_checking", int'(m_chk), int'(tbl[i].e_chk));
            if (i == 5) begin
                chk("tbl_first_exp", int'(m_fe), 4);
                chk("tbl_first_obs", int'(m_fo), 7);
                chk("tbl_halt_after_first", int'(h_halt), 1);
            end
        end

        // Correct counting with wrap: 5 reset cycles then 20 up cycles.
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle(0, 1, 0, 0, 0, 0);
        $display("up-run: err_cnt=%0d checking=%0b", m_err, m_chk);
        chk("uprun_err_cnt", int'(m_err), 0);
        chk("uprun_checking", int'(m_chk), 1);
`ifdef COUNTER_CHECKER_WRAP_STATS_EN
        chk("uprun_wrap_up", int'(m_wu), 1);
        chk("uprun_wrap_dn", int'(m_wd), 0);
`endif

        // Halt mode: two injections three cycles apart.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 1, cnt ^ 5);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 1, cnt ^ 5);
        cycle(0, 1, 0, 0, 0, 0);
        $display("halt: halted=%0b err_cnt=%0d", h_halt, h_err);
        chk("halt_halted", int'(h_halt), 1);
        chk("halt_err_cnt", int'(h_err), 1);
        chk("halt_nohalt_err_cnt", int'(m_err), 2);
        cycle(1, 0, 0, 0, 0, 0);
        chk("halt_rst_halted", int'(h_halt), 0);
        chk("halt_rst_err_cnt", int'(h_err), 0);
        cycle(0, 1, 0, 0, 0, 0);
        chk("halt_resume_checking", int'(h_chk), 1);

        // Saturation: five injections on consecutive checked cycles.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);              // exp=1, out becomes 1
        for (int j = 0; j < 5; j++) cycle(0, 1, 0, 0, 1, cnt ^ 10);
        cycle(0, 1, 0, 0, 0, 0);
        $display("sat: err_cnt(2b)=%0d err_cnt(8b)=%0d first=%0d/%0d", s_err, m_err, s_fe, s_fo);
        chk("sat_err_cnt", int'(s_err), 3);
        chk("sat_wide_err_cnt", int'(m_err), 5);
        chk("sat_first_exp", int'(s_fe), 1);
        chk("sat_first_obs", int'(s_fo), 11);

        // Randomized run against the reference.
        for (int i = 0; i < 2000; i++) begin
            bit r, up, ld, inj;
            int v, iv;
            r   = ($urandom_range(63) == 0);
            up  = 1'($urandom_range(1));
            ld  = ($urandom_range(3) == 0);
            v   = int'($urandom_range(15));
            inj = ($urandom_range(15) == 0);
            iv  = int'($urandom_range(15));
            cycle(r, up, ld, v, inj, iv);
        end
        $display("random: err_cnt=%0d halted=%0b", m_err, h_halt);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
